// File: rtl/btn_step_pkg.sv
// Shared types and constants for the pushbutton step conditioner.
// The FSM state set depends on BTN_AUTOREPEAT_EN (adds the REPEAT state).
package btn_step_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_PRESS_WAIT   = 3'd1,
      ST_PRESSED      = 3'd2,
      ST_RELEASE_WAIT = 3'd3
`ifdef BTN_AUTOREPEAT_EN
      ,
      ST_REPEAT       = 3'd4
`endif
   } btn_state_t;

   // Largest interval the shared counter must span; repeat timings only count when enabled.
   function automatic int cnt_span(input int deb, input int rpt_delay, input int rpt_rate,
                                   input bit autorepeat);
      int span;
      span = deb;
      if (autorepeat) begin
         if (rpt_delay > span) span = rpt_delay;
         if (rpt_rate > span) span = rpt_rate;
      end
      return span;
   endfunction

   function automatic int cnt_width(input int span);
      return (span > 2) ? $clog2(span) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable
// value loaded by the asynchronous reset.
module sync_2ff
   import btn_step_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/btn_step_conditioner.sv
// Debounces an active-low pushbutton into single-cycle step pulses, a held level
// and a step counter. Define BTN_AUTOREPEAT_EN to compile in press-and-hold auto-repeat.
module btn_step_conditioner
   import btn_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 10000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_n,
   output logic        step,
   output logic        held,
   output logic [15:0] step_count
);

`ifdef BTN_AUTOREPEAT_EN
   localparam bit AUTOREPEAT = 1'b1;
`else
   localparam bit AUTOREPEAT = 1'b0;
`endif

   localparam int CNT_MAX = cnt_span(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE, AUTOREPEAT);
   localparam int CNT_W   = cnt_width(CNT_MAX);

   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX - 1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);
`endif

   logic             btn_s;
   logic             repeat_tick;
   btn_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             step_reg, step_next;
   logic             held_reg, held_next;
   logic [15:0]      step_count_reg;

   // Inverted ahead of the synchronizer so that its reset value reads as "not pressed".
   sync_2ff #(
      .RESET_VAL(1'b0)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (~btn_n),
      .q     (btn_s)
   );

`ifdef BTN_AUTOREPEAT_EN
   assign repeat_tick = (state_reg == ST_REPEAT) && btn_s && (cnt_reg == RR_LAST);
`else
   assign repeat_tick = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         step_reg       <= 1'b0;
         held_reg       <= 1'b0;
         step_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         step_reg       <= step_next;
         held_reg       <= held_next;
         step_count_reg <= step_count_reg + 16'(step_next);
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (btn_s) state_next = ST_PRESS_WAIT;
         end
         ST_PRESS_WAIT: begin
            if (!btn_s) state_next = ST_IDLE;
            else if (cnt_reg == DEB_LAST) state_next = ST_PRESSED;
         end
         ST_PRESSED: begin
            if (!btn_s) state_next = ST_RELEASE_WAIT;
`ifdef BTN_AUTOREPEAT_EN
            else if (cnt_reg == RD_LAST) state_next = ST_REPEAT;
`endif
         end
`ifdef BTN_AUTOREPEAT_EN
         ST_REPEAT: begin
            if (!btn_s) state_next = ST_RELEASE_WAIT;
         end
`endif
         ST_RELEASE_WAIT: begin
            // A bounce back to pressed returns without a step and restarts the repeat delay.
            if (btn_s) state_next = ST_PRESSED;
            else if (cnt_reg == DEB_LAST) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      // Saturating so the counter can never wrap while parked in a state.
      if ((state_next != state_reg) || repeat_tick) begin
         cnt_next = '0;
      end else if (cnt_reg != CNT_TOP) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end else begin
         cnt_next = cnt_reg;
      end
   end

   always_comb begin
      step_next = 1'b0;
      case (state_reg)
         ST_PRESS_WAIT: step_next = (state_next == ST_PRESSED);
`ifdef BTN_AUTOREPEAT_EN
         ST_PRESSED:    step_next = (state_next == ST_REPEAT);
         ST_REPEAT:     step_next = repeat_tick;
`endif
         default:       step_next = 1'b0;
      endcase
      step_next = step_next & ~step_reg;

      held_next = (state_next == ST_PRESSED) || (state_next == ST_RELEASE_WAIT);
`ifdef BTN_AUTOREPEAT_EN
      if (state_next == ST_REPEAT) held_next = 1'b1;
`endif
   end

   assign step       = step_reg;
   assign held       = held_reg;
   assign step_count = step_count_reg;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Self-checking bench for btn_step_conditioner: directed scenarios with literal
// expectations plus randomized button activity checked against a run-length model.
module tb_btn_step_conditioner;

   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RR  = 3;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        btn_n;
   logic        step;
   logic        held;
   logic [15:0] step_count;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   btn_step_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_n      (btn_n),
      .step       (step),
      .held       (held),
      .step_count (step_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the press level reaches the debouncer two edges late; a level
   // change is accepted after DEB+1 consecutive equal samples. While held, repeats
   // fire RD samples after the steady run began, then every RR samples.
   bit          m_d1, m_d2, m_held, m_step;
   int          m_ones, m_zeros, m_age;
   logic [15:0] m_count;

   always @(posedge clk or posedge reset) begin : model
      bit s;
      if (reset) begin
         m_d1 = 0; m_d2 = 0; m_held = 0; m_step = 0;
         m_ones = 0; m_zeros = 0; m_age = -1; m_count = '0;
      end else begin
         s = m_d2;
         m_d2 = m_d1;
         m_d1 = ~btn_n;
         if (s) begin m_ones++; m_zeros = 0; end
         else begin m_zeros++; m_ones = 0; end
         m_step = 0;
         if (!m_held) begin
            if (m_ones == DEB + 1) begin m_held = 1; m_step = 1; m_age = 0; end
         end else if (!s) begin
            m_age = -1;
            if (m_zeros == DEB + 1) m_held = 0;
         end else begin
            m_age = (m_age < 0) ? 0 : m_age + 1;
            if (AR && m_age >= RD && ((m_age - RD) % RR) == 0) m_step = 1;
         end
         if (m_step) m_count++;
      end
   end

   always @(negedge clk) begin
      if (!reset && cmp_en) begin
         chk("model_step", 16'(step), 16'(m_step));
         chk("model_held", 16'(held), 16'(m_held));
         chk("model_count", step_count, m_count);
      end
   end

   task automatic idle_release(input int n);
      btn_n = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int base, pulses, exp_pulses, len;
      bit exp_step;
      btn_n = 1'b1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_step", 16'(step), 16'd0);
      chk("reset_held", 16'(held), 16'd0);
      chk("reset_count", step_count, 16'd0);
      reset  = 1'b0;
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);

      // Clean press: step only after edge 6
      btn_n = 1'b0;
      for (int e = 0; e <= 8; e++) begin
         @(negedge clk);
         chk("press_step", 16'(step), 16'(e == 6));
         if (e == 5) chk("press_held_early", 16'(held), 16'd0);
         if (e == 6) begin
            chk("press_held", 16'(held), 16'd1);
            chk("press_count", step_count, 16'd1);
         end
      end
      idle_release(12);
      chk("release_held", 16'(held), 16'd0);
      $display("scenario press: step_count=%0d", step_count);

      // Three-cycle glitch is rejected
      btn_n = 1'b0;
      repeat (3) @(negedge clk);
      btn_n = 1'b1;
      for (int e = 0; e < 10; e++) begin
         @(negedge clk);
         chk("glitch_step", 16'(step), 16'd0);
         chk("glitch_held", 16'(held), 16'd0);
      end
      $display("scenario glitch: step_count=%0d", step_count);

      // Bouncy release
      btn_n = 1'b0;
      repeat (8) @(negedge clk);
      chk("bounce_held_on", 16'(held), 16'd1);
      chk("bounce_count_on", step_count, 16'd2);
      for (int i = 0; i < 8; i++) begin
         btn_n = (i % 4) < 2;
         @(negedge clk);
         chk("bounce_step", 16'(step), 16'd0);
      end
      btn_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bounce_step", 16'(step), 16'd0);
      end
      chk("bounce_held_off", 16'(held), 16'd0);
      chk("bounce_count", step_count, 16'd2);
      $display("scenario bounce: step_count=%0d", step_count);

      // Hold for 40 cycles
      base = int'(step_count);
      pulses = 0;
      btn_n = 1'b0;
      for (int e = 0; e < 40; e++) begin
         @(negedge clk);
         exp_step = (e == 6) || (AR && e >= 16 && ((e - 16) % 3) == 0);
         chk("hold_step", 16'(step), 16'(exp_step));
         pulses += int'(step);
      end
      exp_pulses = AR ? 9 : 1;
      chk("hold_pulses", 16'(pulses), 16'(exp_pulses));
      chk("hold_count", step_count, 16'(base + exp_pulses));
      idle_release(12);
      $display("scenario hold: pulses=%0d step_count=%0d", pulses, step_count);

      // Reset in the middle of a press
      btn_n = 1'b0;
      repeat (5) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("midreset_step", 16'(step), 16'd0);
      chk("midreset_held", 16'(held), 16'd0);
      chk("midreset_count", step_count, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int e = 0; e <= 7; e++) begin
         @(negedge clk);
         chk("postreset_step", 16'(step), 16'(e == 6));
         if (e == 6) begin
            chk("postreset_held", 16'(held), 16'd1);
            chk("postreset_count", step_count, 16'd1);
         end
      end
      idle_release(12);
      $display("scenario midreset: step_count=%0d", step_count);

      // Counter wrap from 16'hFFFF
      force dut.step_count_reg = 16'hFFFF;
      m_count = 16'hFFFF;
      #1 release dut.step_count_reg;
      @(negedge clk);
      chk("wrap_preload", step_count, 16'hFFFF);
      btn_n = 1'b0;
      repeat (7) @(negedge clk);
      chk("wrap_step", 16'(step), 16'd1);
      chk("wrap_count", step_count, 16'h0000);
      idle_release(12);
      $display("scenario wrap: step_count=%0d", step_count);

      // Randomized activity with occasional resets
      for (int seg = 0; seg < 300; seg++) begin
         if ($urandom_range(0, 49) == 0) begin
            #1 reset = 1'b1;
            #1;
            chk("rand_reset_step", 16'(step), 16'd0);
            chk("rand_reset_held", 16'(held), 16'd0);
            chk("rand_reset_count", step_count, 16'd0);
            @(negedge clk);
            reset = 1'b0;
            $display("random seg %0d: reset pulse", seg);
         end else begin
            btn_n = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 6);
            repeat (len) @(negedge clk);
         end
      end
      idle_release(12);
      $display("random phase: step_count=%0d", step_count);

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/btn_step_conditioner.md
BTN_STEP_CONDITIONER -- requirements
Module: btn_step_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the stable-input cycles required to accept a press or release (10 ms at 50 MHz); minimum 2.
REQ-002 Parameter REPEAT_DELAY, default 25000000, SHALL set the cycles from accepted press to first auto-repeat step.
REQ-003 Parameter REPEAT_RATE, default 10000000, SHALL set the cycles between subsequent auto-repeat steps; minimum 2.
REQ-004 clk  input  1  SHALL be the single system clock; all logic on rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 btn_n  input  1  SHALL be the raw, asynchronous, active-low pushbutton.
REQ-007 step  output  1  SHALL be a one-clk registered pulse per accepted press or repeat; it drives the downstream FSM_RAM clock-enable/step input.
REQ-008 held  output  1  SHALL be the registered debounced button level (1 = pressed).
REQ-009 step_count  output  16  SHALL count issued step pulses.

Function
REQ-010 btn_n SHALL pass through a 2-flop synchronizer and be inverted to btn_s (1 = pressed) before any other use.
REQ-011 FSM SHALL have states IDLE, PRESS_WAIT, PRESSED, REPEAT, RELEASE_WAIT, with one shared cycle counter cnt, cleared on every state change.
REQ-012 IDLE: btn_s=1 -> PRESS_WAIT; else stay.
REQ-013 PRESS_WAIT: btn_s=0 -> IDLE with no step (glitch rejected); cnt reaching DEBOUNCE_CYCLES-1 with btn_s=1 -> PRESSED, step=1 and held=1 in the next cycle.
REQ-014 First step SHALL rise exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge sampling btn_n low, given btn_n held low.
REQ-015 PRESSED: btn_s=0 -> RELEASE_WAIT; with autorepeat, cnt reaching REPEAT_DELAY-1 -> REPEAT with one step pulse.
REQ-016 REPEAT: one step pulse every REPEAT_RATE cycles while btn_s=1; btn_s=0 -> RELEASE_WAIT.
REQ-017 RELEASE_WAIT: btn_s=1 -> PRESSED with no step (bounce on release); cnt reaching DEBOUNCE_CYCLES-1 with btn_s=0 -> IDLE, held=0 next cycle.
REQ-018 step SHALL never be high in two consecutive cycles.
REQ-019 step_count SHALL increment by 1 in the cycle step is high, wrapping 16'hFFFF -> 16'h0000 with no flag.
REQ-020 cnt width SHALL be $clog2 of the largest enabled parameter; cnt SHALL never wrap within a state.

Reset
REQ-021 reset=1 SHALL immediately force state=IDLE, cnt=0, synchronizer flops=0 (not pressed), step=0, held=0, step_count=0.
REQ-022 reset asserted mid-press SHALL discard the press; after release of reset with btn_n still low, a full debounce (REQ-014) SHALL be required before the next step.

Configuration
REQ-023 Macro BTN_AUTOREPEAT_EN defined: REPEAT state and REQ-015/016 repeat behaviour compiled in.
REQ-024 BTN_AUTOREPEAT_EN undefined: REPEAT state, REPEAT_DELAY/REPEAT_RATE logic absent; PRESSED exits only to RELEASE_WAIT; exactly one step per press.

Structure
REQ-025 Package btn_step_pkg SHALL hold the FSM state typedef and the synchronizer depth constant (2).
REQ-026 Synchronizer SHALL be a sub-module named sync_2ff (1-bit, async reset to reset value parameter); all else in btn_step_conditioner.

Verification (bench params DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-027 btn_n low at edge 0, held low -> step high only in cycle 6, held=1 from cycle 6, step_count=1.
REQ-028 btn_n low pulse of 3 cycles -> no step, held stays 0, state returns IDLE.
REQ-029 Release with 2-cycle bounces (low/high alternating) then stable high 4+ cycles -> no extra step, held=0 after debounce.
REQ-030 BTN_AUTOREPEAT_EN defined, button held 40 cycles -> steps at cycle 6, 16, 19, 22, ..., step_count matches pulse count; undefined -> single step.
REQ-031 Preload via 65535 presses (or forced count) -> next step gives step_count=0.
REQ-032 reset pulse at cycle 4 of press, btn_n still low -> all outputs 0 immediately; first step 6 cycles after reset release.
